// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates RV32I branch conditions, computes next PC and mispredicts,
// and queues results in an output FIFO. Define BRANCH_STATS_EN to add pop-time statistics counters.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_mispredict,
    output logic            out_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW    = $clog2(OUT_DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(OUT_DEPTH);

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] next_pc;
        logic            mispredict;
        logic            illegal;
    } entry_t;

    entry_t           mem_q [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    entry_t           new_entry;
    entry_t           head;
    logic             push, pop;
    logic             cond;
    logic             bad_f3;

    // Condition evaluation for the incoming branch
    always_comb begin
        cond   = 1'b0;
        bad_f3 = 1'b0;
        case (in_funct3)
            3'b000:  cond = (in_rs1 == in_rs2);
            3'b001:  cond = (in_rs1 != in_rs2);
            3'b100:  cond = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  cond = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  cond = (in_rs1 <  in_rs2);
            3'b111:  cond = (in_rs1 >= in_rs2);
            default: bad_f3 = 1'b1;
        endcase
        new_entry.taken      = cond;
        new_entry.next_pc    = cond ? (in_pc + in_imm) : (in_pc + XLEN'(4));
        new_entry.mispredict = !bad_f3 && (cond != in_pred_taken);
        new_entry.illegal    = bad_f3;
    end

    assign head           = mem_q[rd_ptr_q];
    assign out_valid      = (count_q != '0);
    assign in_ready       = (count_q != DEPTH_C);
    assign push           = in_valid && in_ready;
    assign pop            = out_valid && out_ready;
    assign out_taken      = head.taken;
    assign out_next_pc    = head.next_pc;
    assign out_mispredict = head.mispredict;
    assign out_illegal    = head.illegal;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= new_entry;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    // Counters see only real pops, so a flush cycle adds nothing; they saturate at all-ones
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (pop && !flush) begin
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
            if (head.mispredict && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
`endif

endmodule
